// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// master = word source / serial sink, slave = the serializer itself.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             lsb_first;
  logic             en;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, lsb_first, en,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, lsb_first, en,
    output load_ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: one WIDTH-bit word per frame, one bit per en
// strobe, MSB- or LSB-first, with a registered done pulse after the last bit.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  piso_serializer_if.slave bus
);
  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             dir_q;
  logic             done_q;
  logic             last_bit;
  logic             accept;

  // The final bit leaves on this edge; the same edge may take the next word.
  assign last_bit = (state_q == SHIFT) && bus.en && (cnt_q == LAST);
  assign accept   = bus.load_valid && bus.load_ready;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit && !bus.load_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.load_ready = (state_q == IDLE) || last_bit;
    bus.busy       = (state_q == SHIFT);
    bus.sout_valid = (state_q == SHIFT);
    bus.sout       = 1'b0;
    if (state_q == SHIFT) bus.sout = dir_q ? shreg_q[0] : shreg_q[WIDTH-1];
    bus.done       = done_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_bit;
      if (accept) begin
        shreg_q <= bus.load_data;
        dir_q   <= bus.lsb_first;
        cnt_q   <= '0;
      end else if (last_bit) begin
        shreg_q <= '0;
        cnt_q   <= '0;
      end else if ((state_q == SHIFT) && bus.en) begin
        // Shift toward whichever end drives sout, zero-filling behind.
        shreg_q <= dir_q ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed frames plus a random run,
// all scored against a bit-queue model of the frame in flight.
module tb_piso_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus ();
  piso_serializer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: remaining bits of the current frame in transmit order.
  bit   mq[$];
  logic m_done = 1'b0;
  // {sout, sout_valid, busy, load_ready, done}
  logic [4:0] obs, exp;

  // One clock: apply inputs, sample outputs mid-cycle, then advance the model.
  task automatic tick(input logic v, input logic [W-1:0] d, input logic lf,
                      input logic e, input logic r);
    logic busy_e, ready_e, acc;
    bus.load_valid = v;
    bus.load_data  = d;
    bus.lsb_first  = lf;
    bus.en         = e;
    rst            = r;
    #1;
    busy_e  = (mq.size() != 0);
    ready_e = !busy_e || (e && mq.size() == 1);
    exp = {busy_e ? logic'(mq[0]) : 1'b0, busy_e, busy_e, ready_e, m_done};
    obs = {bus.sout, bus.sout_valid, bus.busy, bus.load_ready, bus.done};
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_done = 1'b0;
    end else begin
      acc    = v && ready_e;
      m_done = busy_e && e && (mq.size() == 1);
      if (busy_e && e) void'(mq.pop_front());
      if (acc) for (int i = 0; i < W; i++) mq.push_back(lf ? d[i] : d[W-1-i]);
    end
    @(negedge clk);
  endtask

  // Runs ncyc idle-input cycles, gathering consumed bits, done pulses and model mismatches.
  task automatic collect(input int ncyc, input bit gap, output logic [W-1:0] seq,
                         output int nb, output int ndone, output int done_at, output int mm);
    logic e;
    seq = '0; nb = 0; ndone = 0; done_at = -1; mm = 0;
    for (int k = 0; k < ncyc; k++) begin
      e = gap ? logic'(k % 2) : 1'b1;
      tick(1'b0, '0, 1'b0, e, 1'b1);
      if (obs !== exp) mm++;
      if (obs[3] && e) begin seq = {seq[W-2:0], obs[4]}; nb++; end
      if (obs[0]) begin ndone++; if (done_at < 0) done_at = k; end
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== 5'b00010) begin
      errors++; $display("FAIL reset_state got %b want %b", obs, 5'b00010);
    end
  endtask

  task automatic test_msb();
    logic [W-1:0] seq; int nb, nd, da, mm;
    tick(1'b1, 8'h1E, 1'b0, 1'b1, 1'b1);
    collect(10, 1'b0, seq, nb, nd, da, mm);
    checks++; if (mm != 0)         begin errors++; $display("FAIL msb_model mismatches %0d want 0", mm); end
    checks++; if (seq !== 8'h1E)   begin errors++; $display("FAIL msb_seq got %h want 1e", seq); end
    checks++; if (nd != 1 || da != 8) begin errors++; $display("FAIL msb_done count %0d at %0d want 1 at 8", nd, da); end
    checks++; if (obs[2:1] !== 2'b01) begin errors++; $display("FAIL msb_idle busy/ready got %b want 01", obs[2:1]); end
  endtask

  task automatic test_lsb();
    logic [W-1:0] seq; int nb, nd, da, mm;
    tick(1'b1, 8'h1E, 1'b1, 1'b1, 1'b1);
    collect(10, 1'b0, seq, nb, nd, da, mm);
    checks++; if (mm != 0)       begin errors++; $display("FAIL lsb_model mismatches %0d want 0", mm); end
    checks++; if (seq !== 8'h78) begin errors++; $display("FAIL lsb_seq got %b want 01111000", seq); end
    checks++; if (nd != 1 || da != 8) begin errors++; $display("FAIL lsb_done count %0d at %0d want 1 at 8", nd, da); end
  endtask

  task automatic test_en_gaps();
    logic [W-1:0] seq; int nb, nd, da, mm;
    tick(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
    collect(18, 1'b1, seq, nb, nd, da, mm);
    checks++; if (mm != 0)       begin errors++; $display("FAIL gaps_model mismatches %0d want 0", mm); end
    checks++; if (seq !== 8'hA5 || nb != 8) begin errors++; $display("FAIL gaps_seq got %h/%0d want a5/8", seq, nb); end
    checks++; if (nd != 1 || da != 16) begin errors++; $display("FAIL gaps_done count %0d at %0d want 1 at 16", nd, da); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq; int nv, nd, mm;
    logic rdy7, rdy_early;
    seq = '0; nv = 0; nd = 0; mm = 0; rdy_early = 1'b0; rdy7 = 1'b0;
    tick(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 18; k++) begin
      tick(k <= 7, 8'h00, 1'b0, 1'b1, 1'b1);
      if (obs !== exp) mm++;
      if (k < 16) begin seq = {seq[14:0], obs[4]}; if (obs[3]) nv++; end
      if (k < 7 && obs[1]) rdy_early = 1'b1;
      if (k == 7) rdy7 = obs[1];
      if (obs[0]) nd++;
    end
    checks++; if (mm != 0) begin errors++; $display("FAIL b2b_model mismatches %0d want 0", mm); end
    checks++; if (seq !== 16'hFF00 || nv != 16) begin errors++; $display("FAIL b2b_seq got %h valid %0d want ff00 16", seq, nv); end
    checks++; if (rdy7 !== 1'b1 || rdy_early) begin errors++; $display("FAIL b2b_ready last %b early %b want 1 0", rdy7, rdy_early); end
    checks++; if (nd != 2) begin errors++; $display("FAIL b2b_done got %0d want 2", nd); end
  endtask

  task automatic test_disturb();
    logic [W-1:0] seq; int nd, mm; logic rdy3;
    seq = '0; nd = 0; mm = 0; rdy3 = 1'b1;
    tick(1'b1, 8'h1E, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick(k == 3, 8'h55, k >= 4, 1'b1, 1'b1);
      if (obs !== exp) mm++;
      if (obs[3]) seq = {seq[W-2:0], obs[4]};
      if (k == 3) rdy3 = obs[1];
      if (obs[0]) nd++;
    end
    checks++; if (mm != 0) begin errors++; $display("FAIL disturb_model mismatches %0d want 0", mm); end
    checks++; if (seq !== 8'h1E || rdy3 !== 1'b0) begin errors++; $display("FAIL disturb_seq got %h ready %b want 1e 0", seq, rdy3); end
    checks++; if (nd != 1) begin errors++; $display("FAIL disturb_done got %0d want 1", nd); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] seq; int nb, nd, da, mm;
    tick(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (obs !== 5'b00010) begin errors++; $display("FAIL rstmid_state got %b want 00010", obs); end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checks++; if (obs[0] !== 1'b0) begin errors++; $display("FAIL rstmid_nodone got %b want 0", obs[0]); end
    tick(1'b1, 8'h1E, 1'b0, 1'b1, 1'b1);
    collect(10, 1'b0, seq, nb, nd, da, mm);
    checks++; if (mm != 0 || seq !== 8'h1E || nd != 1) begin
      errors++; $display("FAIL rstmid_reload seq %h done %0d mism %0d want 1e 1 0", seq, nd, mm);
    end
  endtask

  task automatic test_random();
    int mm, first;
    mm = 0; first = -1;
    for (int k = 0; k < 600; k++) begin
      tick(logic'($urandom_range(1)), W'($urandom), logic'($urandom_range(1)),
           ($urandom_range(3) != 0), ($urandom_range(60) != 0));
      if (obs !== exp) begin mm++; if (first < 0) first = k; end
    end
    checks++; if (mm != 0) begin errors++; $display("FAIL random_model mismatches %0d first cyc %0d want 0", mm, first); end
  endtask

  initial begin
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.lsb_first  = 1'b0;
    bus.en         = 1'b0;
    @(negedge clk);
    test_reset();
    test_msb();
    test_lsb();
    test_en_gaps();
    test_back_to_back();
    test_disturb();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
